backtrack_ctrl: RTL and testbench
=================================

// Module: backtrack_ctrl
// PURPOSE
//  Backtrack sequencer for the DPLL core. On a conflict it drives the trace
//  (imply) stack: pops forced (F) entries and unassigns each one, until it
//  finds the newest decision (D). It pops that decision and pushes its
//  complement back as a forced entry. Reports done, or unsat when no decision
//  is left. Sits between the conflict detector, the trace stack and the
//  variable assignment table.
// PARAMETERS
//  NUM_VARIABLE  128  number of solver variables
//  VAR_W         9    variable index width; matches the stack variable port
//  CNT_W         16   width of the conflict counter and the pop counter
// PORTS
//  clk           in   1      clock
//  reset         in   1      asynchronous, active-low reset
//  conflict      in   1      1-cycle pulse: clause conflict detected
//  stk_empty     in   1      trace stack empty
//  stk_type      in   1      top-of-stack type (D=0 / F=1); valid when !stk_empty
//  stk_val       in   1      top-of-stack assigned value
//  stk_var       in   VAR_W  top-of-stack variable
//  stk_pop       out  1      pop top entry at this clock edge
//  stk_push      out  1      push entry at this clock edge
//  stk_push_type out  1      type of pushed entry (always F=1)
//  stk_push_val  out  1      value of pushed entry
//  stk_push_var  out  VAR_W  variable of pushed entry
//  unassign      out  1      clear the assignment of unassign_var this cycle
//  unassign_var  out  VAR_W  variable to clear
//  assign_en     out  1      write assign_var := assign_val this cycle
//  assign_var    out  VAR_W  variable to write
//  assign_val    out  1      value to write
//  busy          out  1      high in every state except IDLE / UNSAT
//  done          out  1      1-cycle pulse: backtrack complete
//  unsat         out  1      sticky: formula unsatisfiable
//  bt_pops       out  CNT_W  entries popped in the last backtrack
//  conflict_cnt  out  CNT_W  conflicts accepted since reset; saturates
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): state=IDLE; all outputs 0, including
//    both counters and the latched variable/value.
//  - Stack contract: top entry is combinational. A pop or push takes effect at
//    the clock edge where it is asserted. This block never asserts pop and
//    push in the same cycle.
//  - IDLE: conflict=1 -> CHECK; conflict_cnt++ (holds at all-ones);
//    bt_pops clears to 0.
//  - CHECK, stk_empty=1 -> UNSAT. No pop issued.
//  - CHECK, stk_type=F -> stk_pop=1, unassign=1, unassign_var=stk_var,
//    bt_pops++. Stay in CHECK. Rate is one entry per cycle.
//  - CHECK, stk_type=D -> same pop, unassign and bt_pops++. Latch stk_var and
//    stk_val, then -> FLIP.
//  - FLIP: stk_push=1, push_type=1, push_var=latched var, push_val=~latched val.
//    assign_en=1 with the same var/val. Then -> DONE.
//  - DONE: done=1 for exactly one cycle -> IDLE.
//  - UNSAT: unsat=1 and busy=0. Held until reset; conflict is ignored here.
//  - Latency: with k F entries above the top D, done is high in cycle k+3
//    after the edge that samples conflict. bt_pops is then k+1, held until the
//    next accepted conflict.
//  - A conflict while busy is dropped; conflict_cnt does not increment.
//  - No overflow is possible: every push follows a pop.
//  - Outputs from FLIP/CHECK (unassign, assign_en, pop, push) are decoded from
//    state and inputs. They are zero in all other states.
// TESTING
//  - Reset mid-CHECK: stack holds 5 F entries; assert reset=0 after 2 pops ->
//    all outputs 0 at once, state IDLE, no further pops.
//  - Stack (bottom->top) D(v3,1), F(v7,0), F(v9,1); conflict -> pops v9 then
//    v7 then v3 on 3 consecutive cycles. Then push F(v3,0) with assign v3:=0.
//    done high in cycle 5; bt_pops=3.
//  - Top is D(v12,0); conflict -> 1 pop, then push F(v12,1); done in cycle 3;
//    bt_pops=1.
//  - Empty stack; conflict -> unsat=1 on the next cycle, no pop, done never
//    asserted; a later conflict leaves conflict_cnt at 1.
//  - Only F entries (v1,v2); conflict -> 2 pops with unassign, then unsat=1,
//    no push.
//  - Conflict pulses while busy -> ignored, conflict_cnt counts 1. With
//    CNT_W=2, 5 separate conflicts -> conflict_cnt=3 (saturated).

Source files
------------

// File: rtl/backtrack_ctrl.sv
// Backtrack sequencer for the DPLL core: unwinds forced trace entries down to the
// newest decision, flips it into a forced entry, or flags unsat when none is left.
module backtrack_ctrl #(
    parameter int unsigned NUM_VARIABLE = 128,
    parameter int unsigned VAR_W        = 9,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             conflict,
    input  logic             stk_empty,
    input  logic             stk_type,
    input  logic             stk_val,
    input  logic [VAR_W-1:0] stk_var,
    output logic             stk_pop,
    output logic             stk_push,
    output logic             stk_push_type,
    output logic             stk_push_val,
    output logic [VAR_W-1:0] stk_push_var,
    output logic             unassign,
    output logic [VAR_W-1:0] unassign_var,
    output logic             assign_en,
    output logic [VAR_W-1:0] assign_var,
    output logic             assign_val,
    output logic             busy,
    output logic             done,
    output logic             unsat,
    output logic [CNT_W-1:0] bt_pops,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (NUM_VARIABLE > (32'd1 << VAR_W)) begin : g_var_w_check
        $error("VAR_W too narrow for NUM_VARIABLE");
    end

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StFlip,
        StDone,
        StUnsat
    } state_e;

    state_e           r_state;
    logic [VAR_W-1:0] r_var;
    logic             r_val;
    logic             r_busy;
    logic             r_done;
    logic             r_unsat;
    logic [CNT_W-1:0] r_bt_pops;
    logic [CNT_W-1:0] r_conflict_cnt;

    logic w_pop;
    logic w_flip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= StIdle;
            r_var          <= '0;
            r_val          <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_unsat        <= 1'b0;
            r_bt_pops      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (conflict) begin
                        r_state   <= StCheck;
                        r_busy    <= 1'b1;
                        r_bt_pops <= '0;
                        if (r_conflict_cnt != '1) begin
                            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
                        end
                    end
                end
                StCheck: begin
                    if (stk_empty) begin
                        r_state <= StUnsat;
                        r_busy  <= 1'b0;
                        r_unsat <= 1'b1;
                    end else begin
                        r_bt_pops <= r_bt_pops + CNT_W'(1);
                        // A decision ends the unwind; forced entries keep us here.
                        if (!stk_type) begin
                            r_var   <= stk_var;
                            r_val   <= stk_val;
                            r_state <= StFlip;
                        end
                    end
                end
                StFlip: begin
                    r_state <= StDone;
                    r_done  <= 1'b1;
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                StUnsat: begin
                    r_state <= StUnsat;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Stack and assignment-table strobes act on the current top entry, so they
    // are decoded from state and inputs rather than registered.
    assign w_pop  = (r_state == StCheck) && !stk_empty;
    assign w_flip = (r_state == StFlip);

    assign stk_pop       = w_pop;
    assign unassign      = w_pop;
    assign unassign_var  = w_pop ? stk_var : '0;

    assign stk_push      = w_flip;
    assign stk_push_type = w_flip;
    assign stk_push_val  = w_flip & ~r_val;
    assign stk_push_var  = w_flip ? r_var : '0;
    assign assign_en     = w_flip;
    assign assign_val    = w_flip & ~r_val;
    assign assign_var    = w_flip ? r_var : '0;

    assign busy          = r_busy;
    assign done          = r_done;
    assign unsat         = r_unsat;
    assign bt_pops       = r_bt_pops;
    assign conflict_cnt  = r_conflict_cnt;

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Randomized bench for backtrack_ctrl: the bench owns the trace stack as a queue
// and predicts each backtrack from a snapshot of that stack.
module tb_backtrack_ctrl;

    localparam int unsigned VAR_W = 9;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic             t;
        logic             v;
        logic [VAR_W-1:0] vr;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic conflict = 1'b0;
    logic stk_empty = 1'b1;
    logic stk_type = 1'b0;
    logic stk_val = 1'b0;
    logic [VAR_W-1:0] stk_var = '0;

    logic stk_pop, stk_push, stk_push_type, stk_push_val;
    logic [VAR_W-1:0] stk_push_var, unassign_var, assign_var;
    logic unassign, assign_en, assign_val, busy, done, unsat;
    logic [CNT_W-1:0] bt_pops, conflict_cnt;

    logic d2_pop, d2_push, d2_ptype, d2_pval, d2_unassign, d2_aen, d2_aval;
    logic d2_busy, d2_done, d2_unsat;
    logic [VAR_W-1:0] d2_pvar, d2_uvar, d2_avar;
    logic [1:0] d2_bt_pops, d2_cnt;

    entry_t stack[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cnt_model = 0;

    always #5 clk = ~clk;

    backtrack_ctrl #(.NUM_VARIABLE(128), .VAR_W(VAR_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .conflict(conflict), .stk_empty(stk_empty),
        .stk_type(stk_type), .stk_val(stk_val), .stk_var(stk_var),
        .stk_pop(stk_pop), .stk_push(stk_push), .stk_push_type(stk_push_type),
        .stk_push_val(stk_push_val), .stk_push_var(stk_push_var),
        .unassign(unassign), .unassign_var(unassign_var), .assign_en(assign_en),
        .assign_var(assign_var), .assign_val(assign_val), .busy(busy), .done(done),
        .unsat(unsat), .bt_pops(bt_pops), .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter copy sharing all inputs, used for the saturation behaviour.
    backtrack_ctrl #(.NUM_VARIABLE(128), .VAR_W(VAR_W), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .conflict(conflict), .stk_empty(stk_empty),
        .stk_type(stk_type), .stk_val(stk_val), .stk_var(stk_var),
        .stk_pop(d2_pop), .stk_push(d2_push), .stk_push_type(d2_ptype),
        .stk_push_val(d2_pval), .stk_push_var(d2_pvar),
        .unassign(d2_unassign), .unassign_var(d2_uvar), .assign_en(d2_aen),
        .assign_var(d2_avar), .assign_val(d2_aval), .busy(d2_busy), .done(d2_done),
        .unsat(d2_unsat), .bt_pops(d2_bt_pops), .conflict_cnt(d2_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_stack();
        stk_empty = (stack.size() == 0);
        if (stack.size() != 0) begin
            stk_type = stack[$].t;
            stk_val  = stack[$].v;
            stk_var  = stack[$].vr;
        end else begin
            stk_type = 1'b0;
            stk_val  = 1'b0;
            stk_var  = '0;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        conflict = 1'b0;
        #3;
        check_eq("rst_pop", {31'd0, stk_pop}, 0);
        check_eq("rst_push", {31'd0, stk_push}, 0);
        check_eq("rst_unassign", {31'd0, unassign}, 0);
        check_eq("rst_assign_en", {31'd0, assign_en}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_unsat", {31'd0, unsat}, 0);
        check_eq("rst_bt_pops", 32'(bt_pops), 0);
        check_eq("rst_cnt", 32'(conflict_cnt), 0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        cnt_model = 0;
    endtask

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    // Predict and check one full backtrack starting from the current stack.
    task automatic run_conflict(input bit noisy, output bit went_unsat);
        entry_t exp_pops[$];
        bit     has_d;
        int     npops;
        int     exp_size;
        logic   s_pop, s_push, s_ptype, s_pval;
        logic [VAR_W-1:0] s_pvar;
        entry_t d_ent;

        has_d = 1'b0;
        for (int i = stack.size() - 1; i >= 0; i--) begin
            exp_pops.push_back(stack[i]);
            if (stack[i].t == 1'b0) begin
                has_d = 1'b1;
                break;
            end
        end
        npops    = exp_pops.size();
        d_ent    = has_d ? exp_pops[$] : '0;
        exp_size = stack.size() - npops + (has_d ? 1 : 0);

        drive_stack();
        conflict = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        cnt_model++;

        for (int c = 1; c <= npops + 3; c++) begin
            drive_stack();
            conflict = (noisy && c <= npops + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check_eq("pop", {31'd0, stk_pop}, (c <= npops) ? 1 : 0);
            if (c <= npops) begin
                check_eq("unassign", {31'd0, unassign}, 1);
                check_eq("unassign_var", 32'(unassign_var), 32'(exp_pops[c-1].vr));
            end else begin
                check_eq("unassign", {31'd0, unassign}, 0);
            end
            if (has_d && c == npops + 1) begin
                check_eq("push", {31'd0, stk_push}, 1);
                check_eq("push_type", {31'd0, stk_push_type}, 1);
                check_eq("push_var", 32'(stk_push_var), 32'(d_ent.vr));
                check_eq("push_val", {31'd0, stk_push_val}, {31'd0, ~d_ent.v});
                check_eq("assign_en", {31'd0, assign_en}, 1);
                check_eq("assign_var", 32'(assign_var), 32'(d_ent.vr));
                check_eq("assign_val", {31'd0, assign_val}, {31'd0, ~d_ent.v});
            end else begin
                check_eq("push", {31'd0, stk_push}, 0);
                check_eq("assign_en", {31'd0, assign_en}, 0);
            end
            check_eq("done", {31'd0, done}, (has_d && c == npops + 2) ? 1 : 0);
            if (has_d && c == npops + 2) check_eq("bt_pops", 32'(bt_pops), npops);
            check_eq("busy", {31'd0, busy},
                     (has_d ? (c <= npops + 2) : (c <= npops + 1)) ? 1 : 0);
            check_eq("unsat", {31'd0, unsat}, (!has_d && c >= npops + 2) ? 1 : 0);
            s_pop   = stk_pop;
            s_push  = stk_push;
            s_ptype = stk_push_type;
            s_pval  = stk_push_val;
            s_pvar  = stk_push_var;
            @(posedge clk);
            if (s_pop && stack.size() != 0) void'(stack.pop_back());
            if (s_push) stack.push_back('{t: s_ptype, v: s_pval, vr: s_pvar});
            #1;
        end
        conflict = 1'b0;
        if (has_d) check_eq("bt_pops_held", 32'(bt_pops), npops);
        check_eq("conflict_cnt", 32'(conflict_cnt), cnt_model);
        check_eq("conflict_cnt_sat", 32'(d2_cnt), sat3(cnt_model));
        check_eq("stack_size", stack.size(), exp_size);
        went_unsat = !has_d;
    endtask

    initial begin
        bit u;

        do_reset();

        // D(v3,1) F(v7,0) F(v9,1), bottom to top
        stack = '{'{t: 1'b0, v: 1'b1, vr: 9'd3}, '{t: 1'b1, v: 1'b0, vr: 9'd7},
                  '{t: 1'b1, v: 1'b1, vr: 9'd9}};
        run_conflict(1'b0, u);
        check_eq("flip_top_var", 32'(stack[$].vr), 3);
        check_eq("flip_top_val", {31'd0, stack[$].v}, 0);
        check_eq("flip_top_type", {31'd0, stack[$].t}, 1);

        do_reset();
        stack = '{'{t: 1'b0, v: 1'b0, vr: 9'd12}};
        run_conflict(1'b1, u);

        do_reset();
        stack = {};
        run_conflict(1'b0, u);
        check_eq("empty_unsat", {31'd0, u}, 1);
        drive_stack();
        conflict = 1'b1;
        @(posedge clk);
        #1;
        conflict = 1'b0;
        @(negedge clk);
        check_eq("unsat_cnt_hold", 32'(conflict_cnt), 1);
        check_eq("unsat_sticky", {31'd0, unsat}, 1);
        check_eq("unsat_no_pop", {31'd0, stk_pop}, 0);

        do_reset();
        stack = '{'{t: 1'b1, v: 1'b1, vr: 9'd1}, '{t: 1'b1, v: 1'b0, vr: 9'd2}};
        run_conflict(1'b0, u);
        check_eq("f_only_unsat", {31'd0, u}, 1);

        // Five separate conflicts, each on a single decision, saturates the narrow copy.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            stack = '{'{t: 1'b0, v: 1'($urandom_range(0, 1)), vr: 9'($urandom_range(0, 127))}};
            run_conflict(1'b1, u);
        end
        check_eq("sat_cnt2", 32'(d2_cnt), 3);

        // Reset in the middle of unwinding five forced entries.
        do_reset();
        stack = {};
        for (int i = 0; i < 5; i++) stack.push_back('{t: 1'b1, v: 1'b0, vr: 9'(20 + i)});
        drive_stack();
        conflict = 1'b1;
        @(posedge clk);
        #1;
        conflict = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive_stack();
            @(negedge clk);
            check_eq("mid_pop", {31'd0, stk_pop}, 1);
            @(posedge clk);
            if (stk_pop) void'(stack.pop_back());
            #1;
        end
        drive_stack();
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_pop", {31'd0, stk_pop}, 0);
        check_eq("mid_rst_unassign", {31'd0, unassign}, 0);
        check_eq("mid_rst_busy", {31'd0, busy}, 0);
        check_eq("mid_rst_bt_pops", 32'(bt_pops), 0);
        check_eq("mid_rst_cnt", 32'(conflict_cnt), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("mid_rst_no_pop", {31'd0, stk_pop}, 0);
            @(posedge clk);
            if (stk_pop) void'(stack.pop_back());
            #1;
        end
        check_eq("mid_rst_stack", stack.size(), 3);
        reset     = 1'b1;
        cnt_model = 0;

        // Random stacks, repeatedly backtracked until unsat or a conflict budget runs out.
        for (int trial = 0; trial < 20; trial++) begin
            do_reset();
            stack = {};
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) begin
                stack.push_back('{t: 1'($urandom_range(0, 1)), v: 1'($urandom_range(0, 1)),
                                  vr: 9'($urandom_range(0, 127))});
            end
            for (int k = 0; k < 8; k++) begin
                run_conflict(1'($urandom_range(0, 1)), u);
                if (u) break;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
